dma_bus_arbiter: RTL and testbench

Owns the shared memory bus between the CPU and the DMA engine.
- Turns a device-ready interrupt into a one-cycle DMA command.
- Runs the BR/BG handshake with the DMA and stalls the CPU at a safe boundary.
- Muxes address, data and write strobe onto the memory port.
- Raises a completion interrupt to the CPU.
- Sits between the CPU memory interface, the DMA block and memory.

---
 rtl/dma_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// Shared memory bus arbiter between the CPU and the DMA engine: turns device
// interrupts into DMA commands, runs the BR/BG handshake and muxes the memory port.
module dma_bus_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int MAX_GRANT = 16
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   dev_irq,
  output logic                   dma_cmd,
  input  logic                   BR,
  output logic                   BG,
  input  logic                   cpu_busy,
  output logic                   cpu_stall,
  input  logic [WORD_SIZE-1:0]   cpu_addr,
  input  logic [4*WORD_SIZE-1:0] cpu_data,
  input  logic                   cpu_write,
  input  logic [WORD_SIZE-1:0]   dma_addr,
  input  logic [4*WORD_SIZE-1:0] dma_data,
  input  logic                   dma_write,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [4*WORD_SIZE-1:0] mem_data,
  output logic                   mem_write,
  output logic                   dma_done_irq,
  input  logic                   irq_ack,
  output logic                   timeout_err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CMD      = 3'd1;
  localparam logic [2:0] ST_WAIT_BR  = 3'd2;
  localparam logic [2:0] ST_WAIT_CPU = 3'd3;
  localparam logic [2:0] ST_GRANT    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam int            CW       = $clog2(MAX_GRANT + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_GRANT - 1);

  logic [2:0]    state_q, state_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dev_irq_q, dev_irq_d;
  logic          bg_q, bg_d;
  logic          stall_q, stall_d;
  logic          cmd_q, cmd_d;
  logic          done_irq_q, done_irq_d;
  logic          timeout_err_q, timeout_err_d;
  logic          rise_s;
  logic          pend_s;

  // Next-state, pending, grant counter and sticky timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = CNT_ZERO;
    timeout_err_d = timeout_err_q;
    dev_irq_d     = dev_irq;
    rise_s        = dev_irq & ~dev_irq_q;
    // A rise outside IDLE is remembered once; a rise while already pending is lost.
    pend_s        = pending_q | (rise_s & (state_q != ST_IDLE));
    pending_d     = pend_s;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) state_d = ST_CMD;
        else        state_d = ST_IDLE;
      end
      ST_CMD: begin
        state_d = ST_WAIT_BR;
      end
      ST_WAIT_BR: begin
        if (BR && cpu_busy)  state_d = ST_WAIT_CPU;
        else if (BR)         state_d = ST_GRANT;
        else                 state_d = ST_WAIT_BR;
      end
      ST_WAIT_CPU: begin
        if (cpu_busy) state_d = ST_WAIT_CPU;
        else          state_d = ST_GRANT;
      end
      ST_GRANT: begin
        // BR release wins over a timeout landing on the same cycle.
        if (!BR) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_DONE;
          timeout_err_d = 1'b1;
        end else begin
          state_d = ST_GRANT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        if (irq_ack) begin
          state_d   = pend_s ? ST_CMD : ST_IDLE;
          pending_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // Registered outputs decoded from the upcoming state so they align with it.
  always_comb begin
    cmd_d      = (state_d == ST_CMD);
    bg_d       = (state_d == ST_GRANT);
    stall_d    = (state_d == ST_WAIT_CPU) || (state_d == ST_GRANT);
    done_irq_d = (state_d == ST_DONE);
  end

  // State and output registers; reset drops BG without waiting for a clock.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pending_q     <= 1'b0;
      cnt_q         <= CNT_ZERO;
      dev_irq_q     <= 1'b0;
      bg_q          <= 1'b0;
      stall_q       <= 1'b0;
      cmd_q         <= 1'b0;
      done_irq_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      dev_irq_q     <= dev_irq_d;
      bg_q          <= bg_d;
      stall_q       <= stall_d;
      cmd_q         <= cmd_d;
      done_irq_q    <= done_irq_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Memory port mux; a stalled CPU cannot launch a write.
  always_comb begin
    if (bg_q) begin
      mem_addr  = dma_addr;
      mem_data  = dma_data;
      mem_write = dma_write;
    end else begin
      mem_addr  = cpu_addr;
      mem_data  = cpu_data;
      mem_write = cpu_write & ~stall_q;
    end
  end

  assign dma_cmd      = cmd_q;
  assign BG           = bg_q;
  assign cpu_stall    = stall_q;
  assign dma_done_irq = done_irq_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Randomized bench for dma_bus_arbiter against a flag-based transfer model.
module tb_dma_bus_arbiter;
  localparam int WS = 16;
  localparam int MG = 16;

  logic          CLK, reset_n, dev_irq, dma_cmd, BR, BG, cpu_busy, cpu_stall;
  logic [WS-1:0]   cpu_addr, dma_addr, mem_addr;
  logic [4*WS-1:0] cpu_data, dma_data, mem_data;
  logic          cpu_write, dma_write, mem_write, dma_done_irq, irq_ack, timeout_err;

  dma_bus_arbiter #(.WORD_SIZE(WS), .MAX_GRANT(MG)) dut (
    .CLK(CLK), .reset_n(reset_n), .dev_irq(dev_irq), .dma_cmd(dma_cmd),
    .BR(BR), .BG(BG), .cpu_busy(cpu_busy), .cpu_stall(cpu_stall),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_write(cpu_write),
    .dma_addr(dma_addr), .dma_data(dma_data), .dma_write(dma_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .dma_done_irq(dma_done_irq), .irq_ack(irq_ack), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: expected outputs for the current cycle plus transfer bookkeeping.
  bit e_cmd, e_bg, e_stall, e_irq, e_terr;
  bit m_active, m_pend, m_prev_irq;
  int m_gcnt, m_done;

  // Agent / stimulus knobs.
  bit irq_req, br_arm, rnd, force_wr;
  int bg_seen, br_hold, busy_left, ack_delay, ack_cnt;
  int n_cmd_obs, n_bg_obs, n_done_obs;
  bit prev_done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_cmd = 0; e_bg = 0; e_stall = 0; e_irq = 0; e_terr = 0;
    m_active = 0; m_pend = 0; m_prev_irq = 0; m_gcnt = 0;
  endtask

  task automatic agent_clear();
    irq_req = 0; br_arm = 0; bg_seen = 0; busy_left = 0; ack_cnt = 0;
    BR = 0; dev_irq = 0; irq_ack = 0; cpu_busy = 0; prev_done = 0;
  endtask

  // One clock of the model, using the inputs as they stand before the edge.
  task automatic model_step();
    bit rise;
    rise = dev_irq && !m_prev_irq;
    m_prev_irq = dev_irq;
    if (!m_active) begin
      if (rise) begin m_active = 1; e_cmd = 1; end
    end else begin
      if (rise) m_pend = 1;
      if (e_cmd) begin
        e_cmd = 0;
      end else if (e_irq) begin
        if (irq_ack) begin
          e_irq = 0;
          if (m_pend) begin m_pend = 0; e_cmd = 1; end
          else m_active = 0;
        end
      end else if (e_bg) begin
        m_gcnt++;
        if (!BR || m_gcnt == MG) begin
          if (BR) e_terr = 1;
          e_bg = 0; e_stall = 0; e_irq = 1; m_done++;
        end
      end else if (e_stall) begin
        if (!cpu_busy) begin e_bg = 1; m_gcnt = 0; end
      end else if (BR) begin
        e_stall = 1;
        if (!cpu_busy) begin e_bg = 1; m_gcnt = 0; end
      end
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, check, clock, check outputs.
  task automatic tick();
    dev_irq = rnd ? ($urandom_range(0, 15) == 0) : irq_req;
    irq_req = 0;
    if (br_arm) begin
      BR = 1; br_arm = 0; bg_seen = 0;
      if (rnd) br_hold = $urandom_range(0, 20);
    end
    if (e_cmd) br_arm = 1;
    if (e_bg) begin
      bg_seen++;
      if (br_hold > 0 && bg_seen >= br_hold) BR = 0;
    end
    if (e_irq) BR = 0;
    if (rnd) begin
      if (e_stall) cpu_busy = cpu_busy & ($urandom_range(0, 2) != 0);
      else         cpu_busy = ($urandom_range(0, 3) == 0);
      irq_ack = e_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    end else begin
      cpu_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (e_irq) begin irq_ack = (ack_cnt >= ack_delay); ack_cnt++; end
      else begin irq_ack = 0; ack_cnt = 0; end
    end
    cpu_addr  = WS'($urandom);
    dma_addr  = e_bg ? WS'(16'h01F4 + 4 * (bg_seen - 1)) : WS'($urandom);
    cpu_data  = {$urandom, $urandom};
    dma_data  = {$urandom, $urandom};
    cpu_write = force_wr ? 1'b1 : 1'($urandom);
    dma_write = 1'($urandom);
    #1;
    check_eq("mem_addr",  mem_addr,  e_bg ? dma_addr : cpu_addr);
    check_eq("mem_data",  mem_data,  e_bg ? dma_data : cpu_data);
    check_eq("mem_write", mem_write, e_bg ? dma_write : (cpu_write && !e_stall));
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_eq("dma_cmd",      dma_cmd,      e_cmd);
    check_eq("BG",           BG,           e_bg);
    check_eq("cpu_stall",    cpu_stall,    e_stall);
    check_eq("dma_done_irq", dma_done_irq, e_irq);
    check_eq("timeout_err",  timeout_err,  e_terr);
    if (dma_cmd) n_cmd_obs++;
    if (BG) n_bg_obs++;
    if (dma_done_irq && !prev_done) n_done_obs++;
    prev_done = dma_done_irq;
  endtask

  initial begin
    int c0, b0, d0, guard;
    bit p2, p3;
    rnd = 0; force_wr = 0; br_hold = 11; ack_delay = 2; m_done = 0;
    n_cmd_obs = 0; n_bg_obs = 0; n_done_obs = 0;
    cpu_addr = '0; dma_addr = '0; cpu_data = '0; dma_data = '0;
    cpu_write = 0; dma_write = 0;
    agent_clear();
    model_reset();
    reset_n = 0;
    repeat (2) @(negedge CLK);
    check_eq("rst_dma_cmd", dma_cmd, e_cmd);
    check_eq("rst_BG", BG, e_bg);
    check_eq("rst_cpu_stall", cpu_stall, e_stall);
    check_eq("rst_done_irq", dma_done_irq, e_irq);
    check_eq("rst_timeout", timeout_err, e_terr);
    reset_n = 1;
    repeat (2) tick();

    // Idle transfer: BR held for 11 grant cycles.
    c0 = n_cmd_obs; b0 = n_bg_obs; br_hold = 11;
    irq_req = 1;
    repeat (30) tick();
    check_eq("idle_cmd_pulses", n_cmd_obs - c0, 1);
    check_eq("idle_bg_cycles", n_bg_obs - b0, 11);

    // CPU in flight with a write attempt while stalled.
    br_hold = 5; force_wr = 1;
    irq_req = 1;
    guard = 0;
    while (!e_cmd && guard < 10) begin tick(); guard++; end
    check_eq("cpu_reach_cmd", e_cmd, 1);
    busy_left = 4;
    repeat (30) tick();
    force_wr = 0;

    // Timeout: BR never released.
    b0 = n_bg_obs; br_hold = 0; ack_delay = 3;
    irq_req = 1;
    repeat (35) tick();
    check_eq("to_bg_cycles", n_bg_obs - b0, MG);
    check_eq("to_sticky", timeout_err, 1);

    // Pending: second rise during grant is queued, third is dropped.
    c0 = n_cmd_obs; d0 = n_done_obs; br_hold = 8; ack_delay = 2; p2 = 0; p3 = 0;
    irq_req = 1;
    repeat (60) begin
      if (e_bg && bg_seen == 2 && !p2) begin irq_req = 1; p2 = 1; end
      if (e_bg && bg_seen == 5 && !p3) begin irq_req = 1; p3 = 1; end
      tick();
    end
    check_eq("pend_cmd_pulses", n_cmd_obs - c0, 2);
    check_eq("pend_done_count", n_done_obs - d0, 2);

    // Reset asserted asynchronously in the fifth grant cycle.
    br_hold = 0;
    irq_req = 1;
    guard = 0;
    while (!(e_bg && bg_seen >= 4) && guard < 40) begin tick(); guard++; end
    check_eq("rst_reach_grant", BG, 1);
    #2 reset_n = 0;
    #1;
    check_eq("arst_BG", BG, 0);
    check_eq("arst_dma_cmd", dma_cmd, 0);
    check_eq("arst_cpu_stall", cpu_stall, 0);
    check_eq("arst_done_irq", dma_done_irq, 0);
    check_eq("arst_timeout", timeout_err, 0);
    model_reset();
    agent_clear();
    @(posedge CLK);
    @(negedge CLK);
    reset_n = 1;
    c0 = n_cmd_obs;
    repeat (10) tick();
    check_eq("post_rst_no_cmd", n_cmd_obs - c0, 0);

    // Randomized traffic, then drain to idle.
    rnd = 1;
    repeat (3000) tick();
    rnd = 0; br_hold = 5; busy_left = 0; ack_delay = 1;
    repeat (60) tick();
    check_eq("done_total", n_done_obs, m_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
